// File: rtl/lopd_pkg.sv
// Shared types and helpers for the leading-one detector / normaliser pipeline.
// Contents: nibble group width, per-nibble detect record, clog2 and
// leading-zero-from-position helpers used by the pipeline top.
package lopd_pkg;

  localparam int GRP_W = 4;

  // Result of scanning one nibble: position of its highest set bit and
  // whether the nibble is entirely zero.
  typedef struct packed {
    logic [1:0] pos;
    logic       zero;
  } grp_rec_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // An all-zero word reports DATA_W leading zeros; otherwise the count is the
  // distance from the MSB down to the leading one.
  function automatic int lz_from_pos(input int pos, input logic zero, input int data_w);
    return zero ? data_w : (data_w - 1 - pos);
  endfunction

endpackage

// File: rtl/LOPD_4bit.sv
// Leading-one detector for a single nibble; purely combinational leaf.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: nib = 4-bit input group, rec = {local position of highest one, zero flag}.
module LOPD_4bit
  import lopd_pkg::*;
(
  input  logic [GRP_W-1:0] nib,
  output grp_rec_t         rec
);

  always_comb begin
    rec.zero = (nib == '0);
    if (nib[3])      rec.pos = 2'd3;
    else if (nib[2]) rec.pos = 2'd2;
    else if (nib[1]) rec.pos = 2'd1;
    else             rec.pos = 2'd0;
  end

endmodule

// File: rtl/lopd_norm_pipe.sv
// Pipelined leading-one position detector and left normaliser with sideband tag.
// Latency: 2 cycles (S1 nibble detect, S2 combine + shift); 1 word/cycle throughput.
// Backpressure: valid/ready; o_ready is combinational from i_ready, no skid buffer.
// Ports: i_clk/i_rst (sync, active-high); i_valid/o_ready/i_data/i_tag in;
//        o_valid/i_ready/o_pos_one/o_lz_cnt/o_norm_data/o_zero_flag/o_tag out.
module lopd_norm_pipe
  import lopd_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int TAG_W  = 4,
  localparam int POS_W  = clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [POS_W-1:0]  o_pos_one,
  output logic [POS_W:0]    o_lz_cnt,
  output logic [DATA_W-1:0] o_norm_data,
  output logic              o_zero_flag,
  output logic [TAG_W-1:0]  o_tag
);

  localparam int NGRP   = DATA_W / GRP_W;
  localparam int GIDX_W = POS_W - 2;

  logic s1_vld;
  logic s2_vld;
  logic s1_load;
  logic s2_load;

  // A stage may load when it is empty or when its contents move on this cycle.
  assign s2_load = !s2_vld || i_ready;
  assign s1_load = !s1_vld || s2_load;
  assign o_ready = s1_load;
  assign o_valid = s2_vld;

  // ---------------- S1: per-nibble detect ----------------
  grp_rec_t [NGRP-1:0] s1_grp_d;
  grp_rec_t [NGRP-1:0] s1_grp_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic [TAG_W-1:0]    s1_tag_q;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    LOPD_4bit u_lopd (
      .nib (i_data[g*GRP_W +: GRP_W]),
      .rec (s1_grp_d[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld    <= 1'b0;
      s1_grp_q  <= '0;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
    end else if (s1_load) begin
      s1_vld <= i_valid;
      // Payload only captures real words so bubbles (and junk data on an idle
      // bus) leave the previous contents untouched.
      if (i_valid) begin
        s1_grp_q  <= s1_grp_d;
        s1_data_q <= i_data;
        s1_tag_q  <= i_tag;
      end
    end
  end

  // ---------------- S2: combine groups + shift ----------------
  logic [POS_W-1:0]  s2_pos_d;
  logic              s2_zero_d;
  logic [POS_W:0]    s2_lz_d;
  logic [DATA_W-1:0] s2_norm_d;

  always_comb begin
    s2_pos_d  = '0;
    s2_zero_d = 1'b1;
    // Ascending scan: the last non-zero group seen is the most significant.
    for (int g = 0; g < NGRP; g++) begin
      if (!s1_grp_q[g].zero) begin
        s2_pos_d  = {GIDX_W'(g), s1_grp_q[g].pos};
        s2_zero_d = 1'b0;
      end
    end
    s2_lz_d   = (POS_W+1)'(lz_from_pos(int'(s2_pos_d), s2_zero_d, DATA_W));
    // A shift of DATA_W (all-zero input) yields zero, as required.
    s2_norm_d = s1_data_q << s2_lz_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_vld      <= 1'b0;
      o_pos_one   <= '0;
      o_lz_cnt    <= '0;
      o_norm_data <= '0;
      o_zero_flag <= 1'b0;
      o_tag       <= '0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        o_pos_one   <= s2_pos_d;
        o_lz_cnt    <= s2_lz_d;
        o_norm_data <= s2_norm_d;
        o_zero_flag <= s2_zero_d;
        o_tag       <= s1_tag_q;
      end
    end
  end

endmodule
